// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types, instruction field positions and halt decode.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
  typedef enum logic [1:0] {PC_INC, PC_TGT, PC_RST} pc_sel_t;
  localparam int INSTR_W = 16;
  localparam logic [3:0] HALT_OP = 4'hF;
  localparam int CLASS_BIT = 15;
  localparam int OP_HI = 14;
  localparam int OP_LO = 11;
  localparam int FN_HI = 14;
  localparam int FN_LO = 6;
  function automatic logic is_halt(input logic [INSTR_W-1:0] w, input logic [3:0] op);
    return w[CLASS_BIT] && (w[OP_HI:OP_LO] == op);
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC mux (increment with wrap / target / restart).
module pc_next_sel import cpu_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_target,
  input  pc_sel_t           i_sel,
  output logic [ADDR_W-1:0] o_next
);
  assign o_next = (i_sel == PC_RST) ? RESET_PC :
                  (i_sel == PC_TGT) ? i_target : i_pc + ADDR_W'(1);
endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: PC owner and fetch/execute sequencer feeding the control unit.
module instr_fetch_seq #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0] HALT_OP = cpu_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stall,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [15:0]       im_data,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              branch,
  input  logic              imadd_sl,
  input  logic              cond_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retired
);
  import cpu_pkg::*;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic [15:0] r_instr, r_retired;
  logic w_halt, w_redirect, w_pc_en, w_ret_inc, w_ret_clr;
  pc_sel_t w_sel;
  assign w_halt = is_halt(r_instr, HALT_OP);
  assign w_redirect = branch & (imadd_sl | cond_flag);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = run ? FETCH : IDLE;
      FETCH:   w_next = EXEC;
      EXEC:    w_next = stall ? EXEC : (w_halt ? HALTED : FETCH);
      HALTED:  w_next = run ? FETCH : HALTED;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    instr_valid = r_state == EXEC;
    halted = r_state == HALTED;
    w_ret_inc = (r_state == EXEC) && !stall;
    w_ret_clr = (r_state == HALTED) && run;
    w_pc_en = w_ret_inc || w_ret_clr;
    w_sel = (r_state == HALTED) ? PC_RST : (!w_halt && w_redirect) ? PC_TGT : PC_INC;
  end
  pc_next_sel #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_next (
    .i_pc(r_pc), .i_target(branch_target), .i_sel(w_sel), .o_next(w_pc_next)
  );
  // the halt word is cleared as HALTED is entered so the decoder sees a NOP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc <= RESET_PC;
      r_instr <= '0;
      r_retired <= '0;
    end else begin
      if (w_pc_en) r_pc <= w_pc_next;
      r_instr <= (r_state == FETCH) ? im_data : (w_next == HALTED) ? '0 : r_instr;
      r_retired <= w_ret_clr ? '0 : (w_ret_inc && r_retired != 16'hFFFF) ? r_retired + 16'd1 : r_retired;
    end
  assign im_addr = r_pc;
  assign pc = r_pc;
  assign instr = r_instr;
  assign retired = r_retired;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: randomized self-checking bench with a transaction-level PC/retire model.
module tb_instr_fetch_seq;
  logic clk = 0, rst = 0, run = 0, stall = 0, branch = 0, imadd_sl = 0, cond_flag = 0;
  logic [7:0] branch_target = 0, im_addr, pc;
  logic [15:0] im_data, instr, retired;
  logic instr_valid, halted;
  logic [15:0] mem [256];
  logic [7:0] m_pc;
  logic [15:0] m_ret;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;
  assign im_data = mem[im_addr];

  instr_fetch_seq dut (
    .clk(clk), .rst(rst), .run(run), .stall(stall), .im_addr(im_addr), .im_data(im_data),
    .instr(instr), .instr_valid(instr_valid), .branch(branch), .imadd_sl(imadd_sl),
    .cond_flag(cond_flag), .branch_target(branch_target), .pc(pc), .halted(halted), .retired(retired)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_exec(output bit ok);
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin tick; ok = instr_valid; end
  endtask

  // completes the current EXEC slot and advances the model by the architectural rules
  task automatic do_exec(input bit b, input bit ia, input bit cf, input logic [7:0] tgt);
    logic [15:0] w;
    w = mem[m_pc];
    branch = b; imadd_sl = ia; cond_flag = cf; branch_target = tgt; stall = 0;
    tick;
    branch = 0; imadd_sl = 0; cond_flag = 0;
    m_pc = (w[15:11] != 5'b11111 && b && (ia || cf)) ? tgt : m_pc + 8'd1;
    m_ret = (m_ret == 16'hFFFF) ? m_ret : m_ret + 16'd1;
  endtask

  task automatic test_reset;
    rst = 1; #2; rst = 0; tick;
    m_pc = 0; m_ret = 0;
    n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h exp 00", pc); end
    n_cmp++; if (im_addr !== 8'h00) begin n_err++; $display("FAIL reset_im_addr got %h exp 00", im_addr); end
    n_cmp++; if (instr !== 16'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0000", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b exp 0", halted); end
    n_cmp++; if (retired !== 16'h0) begin n_err++; $display("FAIL reset_retired got %h exp 0000", retired); end
  endtask

  task automatic test_start;
    logic [15:0] exp_i [3];
    exp_i = '{16'h0040, 16'h0080, 16'h00C0};
    for (int k = 0; k < 3; k++) mem[k] = exp_i[k];
    tick; tick;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL idle_hold_valid got %b exp 0", instr_valid); end
    run = 1; tick; run = 0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL start_cyc1_valid got %b exp 0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL start_valid[%0d] got %b exp 1", k, instr_valid); end
      n_cmp++; if (instr !== exp_i[k]) begin n_err++; $display("FAIL start_instr[%0d] got %h exp %h", k, instr, exp_i[k]); end
      do_exec(0, 0, 0, 8'h00);
      n_cmp++; if (pc !== 8'(k + 1)) begin n_err++; $display("FAIL start_pc[%0d] got %h exp %h", k, pc, 8'(k + 1)); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL start_fetch_valid[%0d] got %b exp 0", k, instr_valid); end
    end
    n_cmp++; if (retired !== 16'd3) begin n_err++; $display("FAIL start_retired got %0d exp 3", retired); end
  endtask

  task automatic test_jump;
    bit ok;
    for (int i = 0; i < 4 && m_pc != 8'h05; i++) begin wait_exec(ok); do_exec(0, 0, 0, 8'h00); end
    wait_exec(ok);
    n_cmp++; if (!ok || pc !== 8'h05) begin n_err++; $display("FAIL jump_at5 got pc %h valid %b exp 05/1", pc, ok); end
    do_exec(1, 1, 0, 8'h20);
    n_cmp++; if (im_addr !== 8'h20) begin n_err++; $display("FAIL jump_im_addr got %h exp 20", im_addr); end
    n_cmp++; if (retired !== m_ret) begin n_err++; $display("FAIL jump_retired got %h exp %h", retired, m_ret); end
  endtask

  task automatic test_cond;
    bit ok;
    wait_exec(ok);
    do_exec(1, 0, 0, 8'h40);
    n_cmp++; if (pc !== 8'h21) begin n_err++; $display("FAIL cond_not_taken got %h exp 21", pc); end
    wait_exec(ok);
    do_exec(1, 0, 1, 8'h40);
    n_cmp++; if (pc !== 8'h40) begin n_err++; $display("FAIL cond_taken got %h exp 40", pc); end
  endtask

  task automatic test_random;
    bit ok;
    logic [15:0] held;
    for (int n = 0; n < 40; n++) begin
      wait_exec(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_timeout[%0d] got no exec exp exec", n); end
      n_cmp++; if (instr !== mem[m_pc] || pc !== m_pc) begin n_err++; $display("FAIL rnd_exec[%0d] got %h@%h exp %h@%h", n, instr, pc, mem[m_pc], m_pc); end
      held = instr;
      stall = 1;
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        tick;
        n_cmp++; if (instr !== held || pc !== m_pc || retired !== m_ret || instr_valid !== 1'b1) begin
          n_err++; $display("FAIL rnd_stall[%0d] got %h/%h/%h/%b exp %h/%h/%h/1", n, instr, pc, retired, instr_valid, held, m_pc, m_ret);
        end
      end
      do_exec($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
      n_cmp++; if (pc !== m_pc || im_addr !== m_pc || retired !== m_ret || instr_valid !== 1'b0) begin
        n_err++; $display("FAIL rnd_next[%0d] got pc %h addr %h ret %h v %b exp %h/%h/%h/0", n, pc, im_addr, retired, instr_valid, m_pc, m_pc, m_ret);
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    wait_exec(ok);
    do_exec(1, 1, 0, 8'hFF);
    wait_exec(ok);
    n_cmp++; if (pc !== 8'hFF) begin n_err++; $display("FAIL wrap_at_ff got %h exp ff", pc); end
    do_exec(0, 0, 0, 8'h00);
    n_cmp++; if (pc !== 8'h00 || im_addr !== 8'h00) begin n_err++; $display("FAIL wrap_to_0 got %h/%h exp 00/00", pc, im_addr); end
  endtask

  task automatic test_stall_halt;
    bit ok;
    mem[1] = 16'hF800;
    wait_exec(ok);
    stall = 1;
    repeat (3) begin
      tick;
      n_cmp++; if (instr !== 16'h0040 || retired !== m_ret || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold got %h/%h/%b exp 0040/%h/1", instr, retired, instr_valid, m_ret);
      end
    end
    do_exec(0, 0, 0, 8'h00);
    wait_exec(ok);
    n_cmp++; if (instr !== 16'hF800) begin n_err++; $display("FAIL halt_word got %h exp f800", instr); end
    do_exec(1, 1, 1, 8'h77);
    n_cmp++; if (halted !== 1'b1 || instr !== 16'h0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_state got h %b i %h v %b exp 1/0000/0", halted, instr, instr_valid);
    end
    n_cmp++; if (pc !== m_pc || retired !== m_ret) begin n_err++; $display("FAIL halt_pc_ret got %h/%h exp %h/%h", pc, retired, m_pc, m_ret); end
    tick; tick;
    n_cmp++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_stay got %b/%b exp 1/0", halted, instr_valid); end
    mem[0] = 16'hB800;
    run = 1; tick; run = 0;
    m_pc = 8'h00; m_ret = 16'h0;
    n_cmp++; if (halted !== 1'b0 || pc !== 8'h00 || retired !== 16'h0) begin
      n_err++; $display("FAIL restart got h %b pc %h ret %h exp 0/00/0000", halted, pc, retired);
    end
    wait_exec(ok);
    n_cmp++; if (!ok || instr !== 16'hB800) begin n_err++; $display("FAIL restart_exec got %h exp b800", instr); end
    do_exec(0, 0, 0, 8'h00);
    wait_exec(ok);
    n_cmp++; if (!ok || halted !== 1'b0) begin n_err++; $display("FAIL non_halt_class1 got v %b h %b exp 1/0", ok, halted); end
  endtask

  task automatic test_async_reset;
    stall = 1; tick; #2;
    rst = 1; #1;
    n_cmp++; if (instr_valid !== 1'b0 || halted !== 1'b0 || instr !== 16'h0 || pc !== 8'h00 || retired !== 16'h0) begin
      n_err++; $display("FAIL async_rst got v %b h %b i %h pc %h r %h exp 0/0/0000/00/0000", instr_valid, halted, instr, pc, retired);
    end
    #1; rst = 0; stall = 0;
    tick; tick;
    n_cmp++; if (instr_valid !== 1'b0 || pc !== 8'h00) begin n_err++; $display("FAIL post_rst_idle got v %b pc %h exp 0/00", instr_valid, pc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom) & 16'h7FFF;
    test_reset;
    test_start;
    test_jump;
    test_cond;
    test_random;
    test_wrap;
    test_stall_halt;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction fetch sequencer that produces the 16-bit instruction word consumed by the control unit decoder.
- Owns the program counter and drives the synchronous instruction memory address.
- Presents one instruction per execute slot and applies branch redirects using the decoder's branch and IMAdd_SL outputs.
- Sits between instruction memory and the control unit, and exports a retired-instruction counter for the seven-segment/LED debug path.

Parameters:
- ADDR_W, 8, instruction memory address width; PC width.
- RESET_PC, 0, PC value loaded on reset and on restart.
- HALT_OP, 4'hF, value of instr[14:11] (with instr[15]=1) that halts fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- run  input  1  start/restart request; sampled in IDLE and HALTED.
- stall  input  1  hold the current instruction in EXEC.
- im_addr  output  ADDR_W  instruction memory read address; always equals pc.
- im_data  input  16  instruction memory read data; valid one cycle after im_addr.
- instr  output  16  instruction word to the control unit.
- instr_valid  output  1  high while instr is being executed (EXEC state).
- branch  input  1  decoder branch output for instr.
- imadd_sl  input  1  decoder IMAdd_SL: 1 = unconditional jump, 0 = conditional on cond_flag.
- cond_flag  input  1  ALU condition flag (zero) for conditional branch.
- branch_target  input  ADDR_W  target address supplied by the datapath for instr.
- pc  output  ADDR_W  current program counter.
- halted  output  1  high in HALTED state.
- retired  output  16  count of instructions completed.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pc=RESET_PC, instr=16'h0000, instr_valid=0, halted=0, retired=0.
  - instr=0 decodes as a NOP (all control outputs 0).
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE: outputs hold their reset values. run=1 -> FETCH.
- FETCH: one cycle. im_addr=pc is presented. Next cycle -> EXEC, and instr latches im_data on that edge.
- EXEC:
  - instr_valid=1; instr is held stable for the whole state.
  - stall=1: remain in EXEC; pc, instr and retired unchanged.
  - stall=0 and redirect: pc <= branch_target. redirect = branch & (imadd_sl | cond_flag).
  - stall=0 and no redirect: pc <= pc+1, wrapping modulo 2^ADDR_W (e.g. all-ones -> 0).
  - stall=0: retired increments, saturating at 16'hFFFF. Next state -> FETCH.
  - stall=0 and halt opcode (instr[15]=1 and instr[14:11]=HALT_OP): next state is HALTED instead of FETCH. pc <= pc+1 and retired increments. Branch inputs are ignored for the halt word.
- HALTED:
  - halted=1, instr_valid=0, instr <= 16'h0000.
  - run=1: pc <= RESET_PC, retired <= 0, halted cleared -> FETCH.
- Throughput: one instruction per 2 cycles when unstalled; no prefetch, so there is no flush on branch.
- Simultaneous events: stall has priority over redirect and halt. run is ignored in FETCH and EXEC.
- Reset mid-operation: immediate return to reset values regardless of state; no memory access completes.
- instr_valid deasserts combinationally with the state; it is never high in FETCH, IDLE or HALTED.

Decomposition:
- Shared package cpu_pkg:
  - state enum (IDLE, FETCH, EXEC, HALTED);
  - INSTR_W=16;
  - HALT_OP;
  - opcode field positions (bit 15 class bit, [14:11] type-1 opcode, [14:6] type-0 function).
- Sub-module pc_next_sel: combinational next-PC mux (pc+1 / branch_target / RESET_PC) with wrap. It is also reused by the datapath for link-address computation.

Test Plan:
- Reset and start:
  - Stimulus: rst pulse, mem[0..2]=16'h0040,16'h0080,16'h00C0, run=1 one cycle.
  - Response: instr_valid pulses on cycles 2,4,6 after run; instr=0040,0080,00C0; pc=1,2,3; retired=3.
- Unconditional jump:
  - Stimulus: at pc=5 drive branch=1, imadd_sl=1, branch_target=8'h20.
  - Response: next FETCH im_addr=8'h20, retired+1.
- Conditional branch:
  - Stimulus: branch=1, imadd_sl=0, once with cond_flag=0 and once with cond_flag=1, target=8'h40.
  - Response: next pc=pc+1 and 8'h40 respectively.
- Stall then halt:
  - Stimulus: stall=1 for 3 cycles in EXEC, then release; the next instruction is 16'hF800.
  - Response: instr stable and retired frozen during the stall. After 16'hF800, HALTED with halted=1, instr=0, instr_valid=0. run=1 restarts at pc=RESET_PC with retired=0.
- PC wrap:
  - Stimulus: pc=8'hFF, non-branch instruction.
  - Response: pc=8'h00, im_addr=8'h00.
- Async reset mid-EXEC:
  - Stimulus: assert rst between clock edges during stall.
  - Response: all outputs at reset values immediately, before the next clk edge; state IDLE.
